// File: rtl/tdm_demux_frame_if.sv
// Bus interface for the TDM frame demultiplexer.
// Serial side: in_valid, in_sof, in_data (driven by the stream source).
// Frame side:  out_data, out_valid, out_sel, err (driven by the demux).
// Modport master is the source/consumer side. Modport slave is the demux.
interface tdm_demux_frame_if #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int CW  = 2
);
  logic              in_valid;
  logic              in_sof;
  logic [DW-1:0]     in_data;
  logic [NCH*DW-1:0] out_data;
  logic              out_valid;
  logic [CW-1:0]     out_sel;
  logic              err;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, out_sel, err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, out_sel, err
  );
endinterface

// File: rtl/tdm_demux_frame.sv
// Registered 1-to-NCH time-division demultiplexer.
// Collects one word per channel from a round-robin serial stream, starting at
// the word flagged by in_sof. It publishes the whole frame atomically on
// out_data together with a one-cycle out_valid pulse.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus.in_*  serial word stream (valid, start-of-frame, data)
//   bus.out_data  frame bus, channel k at [k*DW +: DW]
//   bus.out_valid one-cycle pulse when a new frame lands on out_data
//   bus.out_sel   slot the next accepted word is written to
//   bus.err       one-cycle pulse on a framing error (missing or early sof)
module tdm_demux_frame #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux_frame_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [NCH*DW-1:0] data_q;
  logic [DW-1:0]     shadow_q [NCH];
  logic              wr_en;
  logic [CW-1:0]     wr_idx;
  logic              publish;

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on the paths that leave it untouched.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = sel_q;
    publish = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.in_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            sel_d   = CW'(1);
            state_d = RUN;
          end else begin
            err_d = 1'b1;            // word without a frame start is dropped
          end
        end
        RUN: begin
          if (bus.in_sof) begin
            // Early start: abandon the partial frame and restart at slot 0.
            err_d  = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
            sel_d  = CW'(1);
          end else if (sel_q == LAST) begin
            // Last word bypasses the shadow buffer straight into out_data.
            publish = 1'b1;
            valid_d = 1'b1;
            sel_d   = '0;
            state_d = IDLE;
          end else begin
            wr_en = 1'b1;
            sel_d = sel_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (publish) begin
        for (int k = 0; k < NCH - 1; k++) data_q[k*DW +: DW] <= shadow_q[k];
        data_q[(NCH-1)*DW +: DW] <= bus.in_data;
      end
    end
  end

  // NOTE: the shadow buffer is small and must read as cleared after reset, so
  // it is reset like ordinary flops rather than left as an unreset memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) shadow_q[k] <= '0;
    end else if (wr_en) begin
      shadow_q[wr_idx] <= bus.in_data;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sel   = sel_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_tdm_demux_frame.sv
// Self-checking bench for tdm_demux_frame (DW=8, NCH=4).
module tb_tdm_demux_frame;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic rst_n;

  tdm_demux_frame_if #(.DW(DW), .NCH(NCH), .CW(CW)) bus ();

  tdm_demux_frame #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v;
    logic          sof;
    logic [DW-1:0] d;
    logic [CW-1:0] sel;
    logic          ov;
    logic          er;
    logic [31:0]   od;
  } vec_t;

  vec_t tbl[$];

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic sof, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [CW-1:0] sel,
                            input logic ov, input logic er, input logic [31:0] od);
    check({tag, " out_sel"},   64'(bus.out_sel),   64'(sel));
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, " err"},       64'(bus.err),       64'(er));
    check({tag, " out_data"},  64'(bus.out_data),  64'(od));
  endtask

  initial begin
    int pulses;

    // Missing start of frame after reset.
    tbl.push_back('{1'b1, 1'b0, 8'h55, 2'd0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h66, 2'd0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 32'h0});
    // Single frame, out_sel 1,2,3,0 after each word.
    tbl.push_back('{1'b1, 1'b1, 8'h11, 2'd1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h22, 2'd2, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h33, 2'd3, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h44, 2'd0, 1'b1, 1'b0, 32'h44332211});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 32'h44332211});
    // Back-to-back frames: valid pulses exactly 4 cycles apart.
    tbl.push_back('{1'b1, 1'b1, 8'hA0, 2'd1, 1'b0, 1'b0, 32'h44332211});
    tbl.push_back('{1'b1, 1'b0, 8'hA1, 2'd2, 1'b0, 1'b0, 32'h44332211});
    tbl.push_back('{1'b1, 1'b0, 8'hA2, 2'd3, 1'b0, 1'b0, 32'h44332211});
    tbl.push_back('{1'b1, 1'b0, 8'hA3, 2'd0, 1'b1, 1'b0, 32'hA3A2A1A0});
    tbl.push_back('{1'b1, 1'b1, 8'hB0, 2'd1, 1'b0, 1'b0, 32'hA3A2A1A0});
    tbl.push_back('{1'b1, 1'b0, 8'hB1, 2'd2, 1'b0, 1'b0, 32'hA3A2A1A0});
    tbl.push_back('{1'b1, 1'b0, 8'hB2, 2'd3, 1'b0, 1'b0, 32'hA3A2A1A0});
    tbl.push_back('{1'b1, 1'b0, 8'hB3, 2'd0, 1'b1, 1'b0, 32'hB3B2B1B0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 32'hB3B2B1B0});
    // Early start of frame: partial 01,02 is discarded.
    tbl.push_back('{1'b1, 1'b1, 8'h01, 2'd1, 1'b0, 1'b0, 32'hB3B2B1B0});
    tbl.push_back('{1'b1, 1'b0, 8'h02, 2'd2, 1'b0, 1'b0, 32'hB3B2B1B0});
    tbl.push_back('{1'b1, 1'b1, 8'h10, 2'd1, 1'b0, 1'b1, 32'hB3B2B1B0});
    tbl.push_back('{1'b1, 1'b0, 8'h20, 2'd2, 1'b0, 1'b0, 32'hB3B2B1B0});
    tbl.push_back('{1'b1, 1'b0, 8'h30, 2'd3, 1'b0, 1'b0, 32'hB3B2B1B0});
    tbl.push_back('{1'b1, 1'b0, 8'h40, 2'd0, 1'b1, 1'b0, 32'h40302010});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 32'h40302010});

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    #12;
    check_outs("reset", 2'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].sof, tbl[i].d);
      check_outs($sformatf("vec%0d", i), tbl[i].sel, tbl[i].ov, tbl[i].er, tbl[i].od);
    end

    // Gapped frame: three idle cycles between words.
    pulses = 0;
    for (int w = 0; w < NCH; w++) begin
      logic [7:0] wd;
      wd = 8'(8'h11 * (w + 1));
      step(1'b1, (w == 0), wd);
      pulses += int'(bus.out_valid);
      check($sformatf("gap w%0d out_sel", w), 64'(bus.out_sel), 64'((w + 1) % NCH));
      for (int g = 0; g < 3 && w < NCH - 1; g++) begin
        step(1'b0, 1'b0, 8'hEE);
        pulses += int'(bus.out_valid);
        check($sformatf("gap w%0d g%0d hold", w, g), 64'(bus.out_sel), 64'(w + 1));
        check($sformatf("gap w%0d g%0d data", w, g), 64'(bus.out_data), 64'h40302010);
      end
    end
    check("gap out_data", 64'(bus.out_data), 64'h44332211);
    step(1'b0, 1'b0, 8'h00);
    pulses += int'(bus.out_valid);
    check("gap valid pulses", 64'(pulses), 64'd1);

    // Reset mid-frame clears outputs without waiting for a clock edge.
    step(1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b0, 8'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("midreset", 2'd0, 1'b0, 1'b0, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Partial frame is gone: a stray non-sof word now flags an error.
    step(1'b1, 1'b0, 8'h99);
    check_outs("post reset", 2'd0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
